// File: rtl/bitonic_stream_sorter_pkg.sv
// Shared types and constants for the sequential bitonic stream sorter.
package bitonic_stream_sorter_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SORT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic DIR_ASC  = 1'b0;
   localparam logic DIR_DESC = 1'b1;

   // A pair sorts ascending when it sits in the lower half of its k-block, flipped for a descending block.
   function automatic logic pairAscending(input logic inLowerHalf, input logic blockDir);
      return (blockDir == DIR_DESC) ? !inLowerHalf : inLowerHalf;
   endfunction

endpackage

// File: rtl/bitonic_stream_sorter_cmp_exchange.sv
// Combinational compare-exchange cell: orders one pair of unsigned words in the requested direction.
module bitonic_stream_sorter_cmp_exchange #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         asc_i,
   output logic [W-1:0] lo_o,
   output logic [W-1:0] hi_o
);

   logic swap;

   always_comb begin
      swap = asc_i ? (a_i > b_i) : (a_i < b_i);
      lo_o = swap ? b_i : a_i;
      hi_o = swap ? a_i : b_i;
   end

endmodule

// File: rtl/bitonic_stream_sorter.sv
// Sequential bitonic sorter: loads N words, runs one compare-exchange per cycle, then streams the block out.
module bitonic_stream_sorter
   import bitonic_stream_sorter_pkg::*;
#(
   parameter int W     = 32,
   parameter int N     = 8,
   parameter int LOG2N = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         dir_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output logic         out_last_o,
   output logic         busy_o
);

   typedef logic [LOG2N-1:0] idx_t;
   typedef logic [3:0]       stage_t;

   localparam idx_t   LastIdx  = idx_t'(N - 1);
   localparam idx_t   LastPair = idx_t'(N / 2 - 1);
   localparam stage_t LastKLog = stage_t'(LOG2N);

   state_e        state_q, state_d;
   idx_t          cnt_q, cnt_d;
   stage_t        kLog_q, kLog_d;
   stage_t        jLog_q, jLog_d;
   idx_t          p_q, p_d;
   logic          dir_q, dir_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic [W-1:0]  mem_q [N];

   idx_t          pairLo, pairHi, cntNext;
   logic          lowerBlock, pairAsc, lastCompare;
   logic          inFire, outFire;
   logic [W-1:0]  cmpLo, cmpHi;

   // Map the pair counter p onto indices (i, i|j) for the current sub-stage j = 2^jLog.
   always_comb begin
      pairLo      = idx_t'(((int'(p_q) >> jLog_q) << (jLog_q + 1)) | (int'(p_q) & ((1 << jLog_q) - 1)));
      pairHi      = pairLo | idx_t'(1 << jLog_q);
      lowerBlock  = ((int'(pairLo) >> kLog_q) & 1) == 0;
      pairAsc     = pairAscending(lowerBlock, dir_q);
      lastCompare = (state_q == ST_SORT) && (p_q == LastPair) && (jLog_q == '0) && (kLog_q == LastKLog);
      cntNext     = cnt_q + 1'b1;
      inFire      = in_valid_i && in_ready_o;
      outFire     = out_valid_o && out_ready_i;
   end

   bitonic_stream_sorter_cmp_exchange #(
      .W (W)
   ) u_cmp (
      .a_i   (mem_q[pairLo]),
      .b_i   (mem_q[pairHi]),
      .asc_i (pairAsc),
      .lo_o  (cmpLo),
      .hi_o  (cmpHi)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD:  if (inFire && cnt_q == LastIdx) state_d = ST_SORT;
         ST_SORT:  if (lastCompare) state_d = ST_DRAIN;
         ST_DRAIN: if (outFire && out_last_q) state_d = ST_LOAD;
         default:  state_d = ST_LOAD;
      endcase
      if (clear_i) state_d = ST_LOAD;
   end

   always_comb begin
      in_ready_o  = (state_q == ST_LOAD);
      out_valid_o = (state_q == ST_DRAIN);
      busy_o      = (state_q != ST_LOAD) || (cnt_q != '0);
      out_data_o  = out_data_q;
      out_last_o  = out_last_q;
   end

   // Counters, direction latch and the registered output word.
   always_comb begin
      cnt_d      = cnt_q;
      kLog_d     = kLog_q;
      jLog_d     = jLog_q;
      p_d        = p_q;
      dir_d      = dir_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      unique case (state_q)
         ST_LOAD: begin
            if (inFire) begin
               if (cnt_q == '0) dir_d = dir_i;
               if (cnt_q == LastIdx) begin
                  cnt_d  = '0;
                  kLog_d = 4'd1;
                  jLog_d = '0;
                  p_d    = '0;
               end else begin
                  cnt_d = cntNext;
               end
            end
         end
         ST_SORT: begin
            if (p_q != LastPair) begin
               p_d = p_q + 1'b1;
            end else begin
               p_d = '0;
               if (jLog_q != '0) begin
                  jLog_d = jLog_q - 1'b1;
               end else if (kLog_q != LastKLog) begin
                  kLog_d = kLog_q + 1'b1;
                  jLog_d = kLog_q;
               end else begin
                  // Word 0 may be written by this very compare when N is 2, so forward it.
                  out_data_d = (pairLo == '0) ? cmpLo : mem_q[0];
                  out_last_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (outFire) begin
               if (out_last_q) begin
                  cnt_d      = '0;
                  out_last_d = 1'b0;
               end else begin
                  cnt_d      = cntNext;
                  out_data_d = mem_q[cntNext];
                  out_last_d = (cntNext == LastIdx);
               end
            end
         end
         default: cnt_d = '0;
      endcase
      if (clear_i) begin
         cnt_d      = '0;
         dir_d      = dir_q;
         out_last_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         kLog_q     <= '0;
         jLog_q     <= '0;
         p_q        <= '0;
         dir_q      <= DIR_ASC;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         kLog_q     <= kLog_d;
         jLog_q     <= jLog_d;
         p_q        <= p_d;
         dir_q      <= dir_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
      end
   end

   // The word array carries no reset; its contents only matter once a full block is loaded.
   always_ff @(posedge clk_i) begin
      if (!clear_i) begin
         if (inFire) begin
            mem_q[cnt_q] <= in_data_i;
         end else if (state_q == ST_SORT) begin
            mem_q[pairLo] <= cmpLo;
            mem_q[pairHi] <= cmpHi;
         end
      end
   end

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// Directed and randomised self-checking bench for bitonic_stream_sorter (N=8, W=32).
module tb_bitonic_stream_sorter;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        dir;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;

   int assertCount = 0;
   int failCount   = 0;

   bitonic_stream_sorter #(
      .W     (32),
      .N     (8),
      .LOG2N (3)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .dir_i       (dir),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one block; dir is the requested value only on the first word and inverted afterwards.
   task automatic applyStimulus(input logic [31:0] words[8], input logic d, input bit randValid);
      int   n     = 0;
      int   guard = 0;
      logic v;
      logic rdyBefore;
      while (n < 8 && guard < 500) begin
         v         = randValid ? ($urandom_range(0, 1) == 1) : 1'b1;
         in_valid  = v;
         in_data   = words[n];
         dir       = (n == 0) ? d : ~d;
         rdyBefore = in_ready;
         tick();
         guard++;
         if (v && rdyBefore) n++;
      end
      in_valid = 1'b0;
      if (n < 8) checkOutput("loadTimeout", n, 8);
   endtask

   // mode 0: always ready, 1: toggling ready, 2: random ready.
   task automatic drainBlock(input logic [31:0] exp[8], input int mode, input int nWords, input string tag);
      int          idx         = 0;
      int          guard       = 0;
      logic        rdy;
      logic        prevStalled = 1'b0;
      logic [31:0] prevData    = '0;
      while (idx < nWords && guard < 400) begin
         case (mode)
            1:       rdy = (guard % 2 == 0);
            2:       rdy = ($urandom_range(0, 1) == 1);
            default: rdy = 1'b1;
         endcase
         out_ready = rdy;
         if (out_valid) begin
            if (prevStalled) checkOutput({tag, "_stallHold"}, out_data, prevData);
            if (rdy) begin
               checkOutput($sformatf("%s_word%0d", tag, idx), out_data, exp[idx]);
               checkOutput($sformatf("%s_last%0d", tag, idx), 32'(out_last), 32'(idx == 7));
               idx++;
            end
            prevStalled = !rdy;
            prevData    = out_data;
         end
         tick();
         guard++;
      end
      out_ready = 1'b1;
      if (idx < nWords) checkOutput({tag, "_drainTimeout"}, idx, nWords);
   endtask

   task automatic refSort(input logic [31:0] w[8], input logic d, output logic [31:0] s[8]);
      logic [31:0] t;
      s = w;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 7 - a; b++) begin
            if ((!d && s[b] > s[b + 1]) || (d && s[b] < s[b + 1])) begin
               t        = s[b];
               s[b]     = s[b + 1];
               s[b + 1] = t;
            end
         end
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_outValid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_inReady"},  32'(in_ready),  32'd1);
      checkOutput({tag, "_busy"},     32'(busy),      32'd0);
   endtask

   initial begin
      logic [31:0] blk [8];
      logic [31:0] exp [8];
      logic        rdir;
      int          latency;

      rst_n     = 1'b0;
      clear     = 1'b0;
      dir       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #12;
      checkIdle("reset");
      checkOutput("reset_outLast", 32'(out_last), 32'd0);
      checkOutput("reset_outData", out_data, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] Block 1: reverse order, ascending, latency check");
      blk = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      applyStimulus(blk, 1'b0, 1'b0);
      checkOutput("b1_inReadySort", 32'(in_ready), 32'd0);
      checkOutput("b1_busySort",    32'(busy),     32'd1);
      in_valid = 1'b1;
      in_data  = 32'hDEAD;
      latency  = 0;
      while (!out_valid && latency < 100) begin
         tick();
         latency++;
      end
      checkOutput("b1_latency", latency, 24);
      drainBlock(exp, 0, 8, "b1");
      in_valid = 1'b0;
      checkIdle("b1_after");

      $display("[TB] Block 2: duplicates and max value, descending");
      blk = '{32'd3, 32'd9, 32'd1, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd5, 32'd5};
      exp = '{32'hFFFFFFFF, 32'd9, 32'd9, 32'd5, 32'd5, 32'd3, 32'd1, 32'd0};
      applyStimulus(blk, 1'b1, 1'b0);
      drainBlock(exp, 0, 8, "b2");

      $display("[TB] Block 3: toggling out_ready");
      blk = '{32'd5, 32'd1, 32'd4, 32'd2, 32'd8, 32'd6, 32'd7, 32'd3};
      exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      applyStimulus(blk, 1'b0, 1'b0);
      drainBlock(exp, 1, 8, "b3");

      $display("[TB] Block 4: reset during sort");
      blk = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      applyStimulus(blk, 1'b1, 1'b0);
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkIdle("rst");
      checkOutput("rst_outLast", 32'(out_last), 32'd0);
      checkOutput("rst_outData", out_data, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      blk = '{32'd7, 32'd0, 32'd6, 32'd1, 32'd5, 32'd2, 32'd4, 32'd3};
      exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
      applyStimulus(blk, 1'b0, 1'b0);
      drainBlock(exp, 0, 8, "b4");

      $display("[TB] Block 5: clear after three drained words");
      blk = '{32'd4, 32'd2, 32'd7, 32'd1, 32'd8, 32'd3, 32'd6, 32'd5};
      exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      applyStimulus(blk, 1'b0, 1'b0);
      drainBlock(exp, 0, 3, "b5");
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkIdle("clear");
      blk = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
      exp = '{32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
      applyStimulus(blk, 1'b1, 1'b0);
      drainBlock(exp, 0, 8, "b6");

      $display("[TB] Random blocks");
      for (int b = 0; b < 10; b++) begin
         for (int n = 0; n < 8; n++) begin
            blk[n] = (b % 2 == 1) ? 32'($urandom_range(0, 15)) : $urandom;
         end
         rdir = ($urandom_range(0, 1) == 1);
         refSort(blk, rdir, exp);
         applyStimulus(blk, rdir, 1'b1);
         drainBlock(exp, 2, 8, $sformatf("rnd%0d", b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
